o_serdes_tx_ctrl: RTL
=====================

Name: o_serdes_tx_ctrl

Overview:
Transmit-side sequencer for one O_SERDES lane, running in the CLK_IN (fabric word clock) domain.
- Holds the serializer quiet until PLL_LOCK is stable, then issues a channel-bond sync pulse.
- Streams words from a valid/ready source into D with LOAD_WORD/OE_IN on a fixed load cadence; substitutes an idle word on underrun.
- Sits between the fabric TX datapath and the O_SERDES primitive instance.

Parameters:
WIDTH, 4, serializer word width; matches O_SERDES WIDTH
LOAD_PERIOD, 1, CLK_IN cycles per word slot (1..255); one LOAD_WORD pulse per slot
SETTLE_CYCLES, 16, consecutive PLL_LOCK-high cycles required before bonding (1..65535)
BOND_CYCLES, 2, length of CHANNEL_BOND_SYNC_IN pulse in cycles (1..255)
IDLE_WORD, 0, word driven on D when a slot has no source data

Ports:
CLK_IN  in  1  word clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
ENABLE  in  1  1 = run lane; 0 = stop at next slot boundary
PLL_LOCK  in  1  PLL lock status (already synchronous to CLK_IN)
S_DATA  in  WIDTH  source word
S_VALID  in  1  source word valid
S_READY  out  1  word accepted this cycle when S_VALID & S_READY
D  out  WIDTH  to O_SERDES D
LOAD_WORD  out  1  to O_SERDES LOAD_WORD
OE_IN  out  1  to O_SERDES OE_IN
CHANNEL_BOND_SYNC_IN  out  1  to O_SERDES CHANNEL_BOND_SYNC_IN
LANE_UP  out  1  high while in RUN
UNDERRUN_CNT  out  16  count of idle-filled slots (see Optional Feature)

Behaviour:
- Reset (RST=1 at an edge): state=WAIT_LOCK; D=0, LOAD_WORD=0, OE_IN=0, CHANNEL_BOND_SYNC_IN=0, LANE_UP=0, UNDERRUN_CNT=0, all counters 0. RST has priority over every other input. Reset mid-RUN drops OE_IN on the next edge; the in-flight word is discarded.
- Outputs other than S_READY are registered. S_READY is combinational: (state==RUN) & ENABLE & PLL_LOCK & (slot_cnt==LOAD_PERIOD-1).
- WAIT_LOCK: all lane outputs 0. Goes to SETTLE when PLL_LOCK=1 and ENABLE=1; settle_cnt cleared.
- SETTLE: settle_cnt increments while PLL_LOCK=1. PLL_LOCK=0 returns to WAIT_LOCK. When settle_cnt reaches SETTLE_CYCLES-1, go to BOND.
- BOND: CHANNEL_BOND_SYNC_IN=1 for exactly BOND_CYCLES cycles, then RUN with slot_cnt=0. PLL_LOCK=0 or ENABLE=0 during BOND aborts to WAIT_LOCK and drops the sync output next edge.
- RUN: LANE_UP=1, OE_IN=1. slot_cnt counts 0..LOAD_PERIOD-1 and wraps. On the edge where slot_cnt==LOAD_PERIOD-1:
  - if S_VALID: D<=S_DATA.
  - else: D<=IDLE_WORD and UNDERRUN_CNT increments (saturates at 0xFFFF).
  - LOAD_WORD<=1 for one cycle on every other edge LOAD_WORD<=0. With LOAD_PERIOD=1, LOAD_WORD stays high continuously.
- Latency: a word accepted at edge N is on D with LOAD_WORD=1 in the cycle following edge N.
- D holds its value between loads.
- PLL_LOCK=0 in RUN: next edge goes to WAIT_LOCK; OE_IN, LOAD_WORD and D go to 0; S_READY drops immediately (combinational).
- ENABLE=0 in RUN: the current slot completes, including its load. The state then goes to WAIT_LOCK at the slot boundary. If the boundary edge is the load edge itself, that load still happens; OE_IN drops the following edge.
- A word is never accepted when S_READY=0; S_VALID alone has no effect.

Optional Feature:
Macro O_SERDES_TX_CTRL_UNDERRUN_CNT_EN.
- Defined: UNDERRUN_CNT is implemented as described; a 16-bit saturating counter cleared only by RST.
- Not defined: no counter flops; UNDERRUN_CNT is tied to 0. All other behaviour is identical.

Test Plan:
1. RST=1 for 2 cycles, PLL_LOCK=0, ENABLE=1 -> all outputs 0, LANE_UP=0. After RST=0, state stays WAIT_LOCK indefinitely.
2. Defaults; PLL_LOCK rises at cycle 10 -> CHANNEL_BOND_SYNC_IN high for exactly 2 cycles starting 16 cycles after lock. Then OE_IN=1 and LANE_UP=1.
3. PLL_LOCK drops at settle count 8 -> back to WAIT_LOCK with no bond pulse. Relock -> full 16-cycle settle restarts.
4. LOAD_PERIOD=3 in RUN, source streams 0x5, 0xA, 0x3 with S_VALID=1 -> S_READY high one cycle in three. D=0x5/0xA/0x3 in consecutive slots, LOAD_WORD pulses every 3rd cycle.
5. RUN, S_VALID=0 for 4 slots, IDLE_WORD=0x0 -> D=0 for each of those slots and UNDERRUN_CNT=4. With the macro undefined, UNDERRUN_CNT=0.
6. In RUN, PLL_LOCK=0 for one cycle -> next edge OE_IN=0, LOAD_WORD=0, D=0, LANE_UP=0; S_READY=0 the same cycle. Re-entry to RUN requires settle plus bond again.

Source files
------------

// File: rtl/o_serdes_tx_ctrl_if.sv
// Handshake and serializer-facing signals for one O_SERDES TX lane.
// The master drives the source and control inputs; the slave (the controller) drives the lane outputs.
interface o_serdes_tx_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             ENABLE;
   logic             PLL_LOCK;
   logic [WIDTH-1:0] S_DATA;
   logic             S_VALID;
   logic             S_READY;
   logic [WIDTH-1:0] D;
   logic             LOAD_WORD;
   logic             OE_IN;
   logic             CHANNEL_BOND_SYNC_IN;
   logic             LANE_UP;
   logic [15:0]      UNDERRUN_CNT;

   modport master (
      output ENABLE, PLL_LOCK, S_DATA, S_VALID,
      input  S_READY, D, LOAD_WORD, OE_IN, CHANNEL_BOND_SYNC_IN, LANE_UP, UNDERRUN_CNT
   );

   modport slave (
      input  ENABLE, PLL_LOCK, S_DATA, S_VALID,
      output S_READY, D, LOAD_WORD, OE_IN, CHANNEL_BOND_SYNC_IN, LANE_UP, UNDERRUN_CNT
   );
endinterface

// File: rtl/o_serdes_tx_ctrl.sv
// TX lane sequencer: waits for stable PLL lock, pulses channel-bond sync, then streams words into O_SERDES.
// Define O_SERDES_TX_CTRL_UNDERRUN_CNT_EN to build the saturating underrun counter; otherwise UNDERRUN_CNT is 0.
module o_serdes_tx_ctrl #(
   parameter int               WIDTH         = 4,
   parameter int               LOAD_PERIOD   = 1,
   parameter int               SETTLE_CYCLES = 16,
   parameter int               BOND_CYCLES   = 2,
   parameter logic [WIDTH-1:0] IDLE_WORD     = '0
) (
   input logic               CLK_IN,
   input logic               RST,
   o_serdes_tx_ctrl_if.slave bus
);
   typedef enum logic [1:0] {WAIT_LOCK, SETTLE, BOND, RUN} state_t;

   localparam logic [7:0]  SLOT_LAST   = 8'(LOAD_PERIOD - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  BOND_LAST   = 8'(BOND_CYCLES - 1);

   state_t           state, state_nxt;
   logic [15:0]      settle_cnt, settle_nxt;
   logic [7:0]       bond_cnt, bond_nxt;
   logic [7:0]       slot_cnt, slot_nxt;
   logic             stop_req, stop_nxt;
   logic [WIDTH-1:0] d_q, d_nxt;
   logic             load_q, load_nxt;
   logic             oe_q, oe_nxt;
   logic             cbs_q, cbs_nxt;
   logic             up_q;
   logic             slot_end, s_ready, accept;

   assign slot_end = (slot_cnt == SLOT_LAST);
   assign s_ready  = (state == RUN) & bus.ENABLE & bus.PLL_LOCK & slot_end;
   assign accept   = s_ready & bus.S_VALID;

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      bond_nxt   = bond_cnt;
      slot_nxt   = slot_cnt;
      stop_nxt   = stop_req;
      d_nxt      = '0;
      load_nxt   = 1'b0;
      oe_nxt     = 1'b0;
      cbs_nxt    = 1'b0;
      case (state)
         WAIT_LOCK: begin
            settle_nxt = '0;
            stop_nxt   = 1'b0;
            if (bus.PLL_LOCK && bus.ENABLE) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!bus.PLL_LOCK) begin
               state_nxt = WAIT_LOCK;
            end else if (settle_cnt == SETTLE_LAST) begin
               state_nxt = BOND;
               bond_nxt  = '0;
               cbs_nxt   = 1'b1;
            end else begin
               settle_nxt = settle_cnt + 16'd1;
            end
         end
         BOND: begin
            if (!bus.PLL_LOCK || !bus.ENABLE) begin
               state_nxt = WAIT_LOCK;
            end else if (bond_cnt == BOND_LAST) begin
               state_nxt = RUN;
               slot_nxt  = '0;
               oe_nxt    = 1'b1;
            end else begin
               bond_nxt = bond_cnt + 8'd1;
               cbs_nxt  = 1'b1;
            end
         end
         RUN: begin
            // Lock loss discards the slot in flight; a disable request waits for the slot boundary.
            if (!bus.PLL_LOCK) begin
               state_nxt = WAIT_LOCK;
            end else begin
               oe_nxt   = 1'b1;
               d_nxt    = d_q;
               stop_nxt = stop_req | ~bus.ENABLE;
               if (slot_end) begin
                  slot_nxt = '0;
                  load_nxt = 1'b1;
                  d_nxt    = accept ? bus.S_DATA : IDLE_WORD;
                  if (stop_nxt) state_nxt = WAIT_LOCK;
               end else begin
                  slot_nxt = slot_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         state      <= WAIT_LOCK;
         settle_cnt <= '0;
         bond_cnt   <= '0;
         slot_cnt   <= '0;
         stop_req   <= 1'b0;
         d_q        <= '0;
         load_q     <= 1'b0;
         oe_q       <= 1'b0;
         cbs_q      <= 1'b0;
         up_q       <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         bond_cnt   <= bond_nxt;
         slot_cnt   <= slot_nxt;
         stop_req   <= stop_nxt;
         d_q        <= d_nxt;
         load_q     <= load_nxt;
         oe_q       <= oe_nxt;
         cbs_q      <= cbs_nxt;
         up_q       <= (state_nxt == RUN);
      end
   end

`ifdef O_SERDES_TX_CTRL_UNDERRUN_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] underrun_q;
   logic        underrun_inc;

   // An idle-filled slot is any load edge in RUN that did not take a source word.
   assign underrun_inc = (state == RUN) & bus.PLL_LOCK & slot_end & ~accept;

   always_ff @(posedge CLK_IN) begin
      if (RST)               underrun_q <= '0;
      else if (underrun_inc) underrun_q <= sat_inc16(underrun_q);
   end

   assign bus.UNDERRUN_CNT = underrun_q;
`else
   assign bus.UNDERRUN_CNT = '0;
`endif

   assign bus.S_READY              = s_ready;
   assign bus.D                    = d_q;
   assign bus.LOAD_WORD            = load_q;
   assign bus.OE_IN                = oe_q;
   assign bus.CHANNEL_BOND_SYNC_IN = cbs_q;
   assign bus.LANE_UP              = up_q;
endmodule
